// File: rtl/db_ctrl.sv
// Sequencing/arbitration controller for the 64-byte USB endpoint data buffer.
// Grants single-cycle store/get strobes, tracks occupancy, and records overrun/underrun errors.
module db_ctrl #(
    parameter int DEPTH = 64,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             flush,
    input  logic             rx_packet_start,
    input  logic             rx_packet_done,
    input  logic             rx_error,
    input  logic             store_rx_req,
    input  logic             get_rx_req,
    input  logic             store_tx_req,
    input  logic             tx_packet_start,
    input  logic             tx_packet_done,
    input  logic             get_tx_req,
    output logic             store_rx_data,
    output logic             store_tx_data,
    output logic             get_rx_data,
    output logic             get_tx_data,
    output logic             db_flush,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic             buff_full,
    output logic             buff_empty,
    output logic             rx_data_ready,
    output logic             overrun_err,
    output logic             underrun_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_ACTIVE = 3'd1,
        RX_READY  = 3'd2,
        TX_LOAD   = 3'd3,
        TX_SEND   = 3'd4
    } state_t;

    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    state_t           state_q, state_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             db_flush_q, db_flush_d;
    logic             overrun_q, overrun_d;
    logic             underrun_q, underrun_d;

    logic             cmd;
    logic             live;
    logic             can_store;
    logic             can_get;
    logic             store_rx_g;
    logic             store_tx_g;
    logic             get_rx_g;
    logic             get_tx_g;
    logic             flush_evt;
    logic [OCC_W-1:0] inc;
    logic [OCC_W-1:0] dec;
    logic [OCC_W-1:0] occ_nxt;
    logic             store_denied;
    logic             get_denied;

    always_comb begin
        cmd        = clear | flush;
        // Grants are held off while reset is asserted and while a host command cancels the cycle.
        live       = n_rst & ~cmd;
        can_store  = (occ_q < OCC_MAX);
        can_get    = (occ_q != '0);
        store_rx_g = 1'b0;
        store_tx_g = 1'b0;
        get_rx_g   = 1'b0;
        get_tx_g   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_packet_start) begin
                    store_tx_g = live & store_tx_req & can_store;
                end
            end
            RX_ACTIVE: store_rx_g = live & store_rx_req & can_store;
            RX_READY:  get_rx_g   = live & get_rx_req & can_get;
            TX_LOAD:   store_tx_g = live & store_tx_req & can_store;
            TX_SEND:   get_tx_g   = live & get_tx_req & can_get;
            default: ;
        endcase

        inc     = {{(OCC_W-1){1'b0}}, store_rx_g | store_tx_g};
        dec     = {{(OCC_W-1){1'b0}}, get_rx_g | get_tx_g};
        occ_nxt = occ_q + inc - dec;

        state_d   = state_q;
        flush_evt = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_packet_start) begin
                    state_d = RX_ACTIVE;
                end else if (store_tx_g) begin
                    state_d = TX_LOAD;
                end
            end
            RX_ACTIVE: begin
                // An aborted packet discards everything received so far.
                if (rx_error) begin
                    flush_evt = 1'b1;
                    state_d   = IDLE;
                end else if (rx_packet_done) begin
                    state_d = (occ_nxt != '0) ? RX_READY : IDLE;
                end
            end
            RX_READY: begin
                if (occ_nxt == '0) begin
                    state_d = IDLE;
                end
            end
            TX_LOAD: begin
                if (tx_packet_start) begin
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                // Bytes not fetched by the TX engine are dropped with the packet.
                if (tx_packet_done) begin
                    flush_evt = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmd) begin
            flush_evt = 1'b1;
            state_d   = IDLE;
        end

        occ_d      = flush_evt ? '0 : occ_nxt;
        db_flush_d = flush_evt;

        store_denied = (store_rx_req & ~store_rx_g) | (store_tx_req & ~store_tx_g);
        get_denied   = (get_rx_req & ~get_rx_g) | (get_tx_req & ~get_tx_g);

        // Requests cancelled by a host command are not counted as errors.
        overrun_d  = overrun_q | (~cmd & store_denied);
        underrun_d = underrun_q | (~cmd & get_denied);
        if (clear) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            occ_q      <= '0;
            db_flush_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            db_flush_q <= db_flush_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign store_rx_data    = store_rx_g;
    assign store_tx_data    = store_tx_g;
    assign get_rx_data      = get_rx_g;
    assign get_tx_data      = get_tx_g;
    assign db_flush         = db_flush_q;
    assign buffer_occupancy = occ_q;
    assign buff_full        = (occ_q == OCC_MAX);
    assign buff_empty       = (occ_q == '0);
    assign rx_data_ready    = (state_q == RX_READY);
    assign overrun_err      = overrun_q;
    assign underrun_err     = underrun_q;

endmodule

// File: tb/tb_db_ctrl.sv
// Directed bench for db_ctrl: RX/TX sequences, capacity limits, host commands and async reset.
module tb_db_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear, flush;
    logic       rx_packet_start, rx_packet_done, rx_error, store_rx_req, get_rx_req;
    logic       store_tx_req, tx_packet_start, tx_packet_done, get_tx_req;
    logic       store_rx_data, store_tx_data, get_rx_data, get_tx_data, db_flush;
    logic [6:0] buffer_occupancy;
    logic       buff_full, buff_empty, rx_data_ready, overrun_err, underrun_err;

    int n_pass  = 0;
    int n_total = 0;
    int grants;

    db_ctrl #(.DEPTH(64), .OCC_W(7)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .clear            (clear),
        .flush            (flush),
        .rx_packet_start  (rx_packet_start),
        .rx_packet_done   (rx_packet_done),
        .rx_error         (rx_error),
        .store_rx_req     (store_rx_req),
        .get_rx_req       (get_rx_req),
        .store_tx_req     (store_tx_req),
        .tx_packet_start  (tx_packet_start),
        .tx_packet_done   (tx_packet_done),
        .get_tx_req       (get_tx_req),
        .store_rx_data    (store_rx_data),
        .store_tx_data    (store_tx_data),
        .get_rx_data      (get_rx_data),
        .get_tx_data      (get_tx_data),
        .db_flush         (db_flush),
        .buffer_occupancy (buffer_occupancy),
        .buff_full        (buff_full),
        .buff_empty       (buff_empty),
        .rx_data_ready    (rx_data_ready),
        .overrun_err      (overrun_err),
        .underrun_err     (underrun_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chkn(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic idle_in();
        clear = 0; flush = 0;
        rx_packet_start = 0; rx_packet_done = 0; rx_error = 0;
        store_rx_req = 0; get_rx_req = 0;
        store_tx_req = 0; tx_packet_start = 0; tx_packet_done = 0; get_tx_req = 0;
    endtask

    // Inputs change 1 time unit after a rising edge and are zeroed again after the next one.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_in();
        n_rst = 1'b0;
        #12;
        chkn("rst_occ", buffer_occupancy, 7'd0);
        chk1("rst_empty", buff_empty, 1'b1);
        chk1("rst_full", buff_full, 1'b0);
        chk1("rst_flush", db_flush, 1'b0);
        chk1("rst_ovr", overrun_err, 1'b0);
        chk1("rst_und", underrun_err, 1'b0);
        chk1("rst_ready", rx_data_ready, 1'b0);
        chk1("rst_grant", store_rx_data | store_tx_data | get_rx_data | get_tx_data, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // RX three bytes then host drains them
        rx_packet_start = 1; tick();
        for (int i = 0; i < 3; i++) begin
            store_rx_req = 1; settle();
            chk1("rx_store_grant", store_rx_data, 1'b1);
            tick();
        end
        rx_packet_done = 1; tick();
        chkn("rx_occ3", buffer_occupancy, 7'd3);
        chk1("rx_ready", rx_data_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            get_rx_req = 1; settle();
            chk1("rx_get_grant", get_rx_data, 1'b1);
            tick();
        end
        chkn("rx_drain_occ", buffer_occupancy, 7'd0);
        chk1("rx_drain_ready", rx_data_ready, 1'b0);
        chk1("rx_drain_empty", buff_empty, 1'b1);

        // Fill to capacity; the 65th store is refused
        grants = 0;
        for (int i = 0; i < 65; i++) begin
            store_tx_req = 1; settle();
            if (store_tx_data) grants++;
            if (i == 63) chk1("full_last_grant", store_tx_data, 1'b1);
            if (i == 64) chk1("full_denied", store_tx_data, 1'b0);
            tick();
        end
        chkn("full_grants", 7'(grants), 7'd64);
        chkn("full_occ", buffer_occupancy, 7'd64);
        chk1("full_flag", buff_full, 1'b1);
        chk1("full_ovr", overrun_err, 1'b1);
        clear = 1; tick();
        chkn("clr_occ", buffer_occupancy, 7'd0);
        chk1("clr_flush", db_flush, 1'b1);
        chk1("clr_ovr", overrun_err, 1'b0);
        tick();
        chk1("clr_flush_once", db_flush, 1'b0);

        // Store collides with clear
        for (int i = 0; i < 5; i++) begin
            store_tx_req = 1; tick();
        end
        chkn("sim_occ5", buffer_occupancy, 7'd5);
        store_tx_req = 1; clear = 1; settle();
        chk1("sim_no_grant", store_tx_data, 1'b0);
        tick();
        chkn("sim_occ0", buffer_occupancy, 7'd0);
        chk1("sim_flush", db_flush, 1'b1);
        chk1("sim_ovr", overrun_err, 1'b0);

        // rx_error after ten stores, then a stray host read
        rx_packet_start = 1; tick();
        for (int i = 0; i < 10; i++) begin
            store_rx_req = 1; tick();
        end
        chkn("err_occ10", buffer_occupancy, 7'd10);
        rx_error = 1; tick();
        chk1("err_flush", db_flush, 1'b1);
        chkn("err_occ0", buffer_occupancy, 7'd0);
        chk1("err_ready", rx_data_ready, 1'b0);
        get_rx_req = 1; settle();
        chk1("err_get_denied", get_rx_data, 1'b0);
        tick();
        chk1("err_und", underrun_err, 1'b1);
        chk1("err_ovr_clean", overrun_err, 1'b0);
        clear = 1; tick();
        chk1("err_und_cleared", underrun_err, 1'b0);

        // RX start wins over host store in IDLE
        rx_packet_start = 1; store_tx_req = 1; settle();
        chk1("arb_tx_denied", store_tx_data, 1'b0);
        tick();
        chk1("arb_ovr", overrun_err, 1'b1);
        store_rx_req = 1; settle();
        chk1("arb_rx_active", store_rx_data, 1'b1);
        tick();
        rx_packet_done = 1; tick();
        chk1("arb_ready", rx_data_ready, 1'b1);
        flush = 1; tick();
        chk1("fl_flush", db_flush, 1'b1);
        chkn("fl_occ", buffer_occupancy, 7'd0);
        chk1("fl_ready", rx_data_ready, 1'b0);
        chk1("fl_ovr_kept", overrun_err, 1'b1);

        // TX send drops residue on packet done
        for (int i = 0; i < 4; i++) begin
            store_tx_req = 1; tick();
        end
        chkn("tx_occ4", buffer_occupancy, 7'd4);
        store_rx_req = 1; settle();
        chk1("tx_wrong_store", store_rx_data, 1'b0);
        tick();
        tx_packet_start = 1; tick();
        for (int i = 0; i < 2; i++) begin
            get_tx_req = 1; settle();
            chk1("tx_get_grant", get_tx_data, 1'b1);
            tick();
        end
        chkn("tx_occ2", buffer_occupancy, 7'd2);
        tx_packet_done = 1; tick();
        chkn("tx_done_occ", buffer_occupancy, 7'd0);
        chk1("tx_done_flush", db_flush, 1'b1);
        get_tx_req = 1; settle();
        chk1("tx_idle_get", get_tx_data, 1'b0);
        tick();
        chk1("tx_und", underrun_err, 1'b1);

        // Asynchronous reset in the middle of an RX packet
        rx_packet_start = 1; tick();
        store_rx_req = 1; tick();
        store_rx_req = 1; tick();
        chkn("ar_occ2", buffer_occupancy, 7'd2);
        #2;
        n_rst = 1'b0;
        #1;
        chkn("ar_occ", buffer_occupancy, 7'd0);
        chk1("ar_empty", buff_empty, 1'b1);
        chk1("ar_ovr", overrun_err, 1'b0);
        chk1("ar_und", underrun_err, 1'b0);
        chk1("ar_flush", db_flush, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        store_rx_req = 1; settle();
        chk1("ar_idle_store", store_rx_data, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
